boot_loader: RTL

- Upstream feeder of the byte-addressable instruction/data memory.
- After reset it owns the memory write port and holds the CPU stalled.
- It accepts a byte stream (from a UART receiver) framed as a 4-byte little-endian word count N followed by N little-endian words.
- It writes word k to address BASE_ADDR+4k, then releases the CPU.

---
 rtl/boot_loader_pkg.sv | 14 +
 rtl/byte_packer.sv | 36 +++
 rtl/boot_loader.sv | 136 +++++++++++++
 3 files changed

// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the boot loader: FSM state encoding and
// the width of the little-endian word count header.
package boot_loader_pkg;

    typedef enum logic [1:0] {
        StHdr   = 2'd0,
        StData  = 2'd1,
        StDone  = 2'd2,
        StError = 2'd3
    } state_e;

    localparam int unsigned HdrWidth = 32;

endpackage

// File: rtl/byte_packer.sv
// Four-byte little-endian word assembler. The first byte lands in bits [7:0].
// word_valid pulses combinationally on the acceptance of the fourth byte.
module byte_packer
    import boot_loader_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                accept,
    input  logic [7:0]          in_data,
    output logic [HdrWidth-1:0] word,
    output logic                word_valid
);

    logic [1:0]            cnt_q;
    logic [HdrWidth-9:0]   shift_q;

    // Only the first three bytes are stored; the fourth is merged in on the fly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 2'd0;
            shift_q <= '0;
        end else if (clr) begin
            cnt_q   <= 2'd0;
        end else if (accept) begin
            cnt_q   <= cnt_q + 2'd1;
            shift_q <= {in_data, shift_q[HdrWidth-9:8]};
        end
    end

    always_comb begin
        word       = {in_data, shift_q};
        word_valid = accept && (cnt_q == 2'd3);
    end

endmodule

// File: rtl/boot_loader.sv
// Loads a length-prefixed little-endian word stream into memory starting at
// BASE_ADDR while holding the CPU, then releases it once the last write lands.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int unsigned           MAX_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  restart,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wd,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned CntW = $clog2(MAX_WORDS + 1);

    state_e                state_q, state_d;
    logic [CntW-1:0]       word_cnt_q, word_cnt_d;
    logic [CntW-1:0]       n_q, n_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wd_q, mem_wd_d;
    logic                  armed_q;

    logic                  accept;
    logic                  packer_clr;
    logic [HdrWidth-1:0]   word;
    logic                  word_valid;

    byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (packer_clr),
        .accept     (accept),
        .in_data    (in_data),
        .word       (word),
        .word_valid (word_valid)
    );

    // Keeps in_ready low until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StHdr;
            word_cnt_q <= '0;
            n_q        <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= BASE_ADDR;
            mem_wd_q   <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            n_q        <= n_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_wd_q   <= mem_wd_d;
        end
    end

    assign in_ready = armed_q && ((state_q == StHdr) || (state_q == StData));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        n_d        = n_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_wd_d   = mem_wd_q;
        packer_clr = 1'b0;

        unique case (state_q)
            StHdr: begin
                if (word_valid) begin
                    if (word == '0) begin
                        state_d = StDone;
                    end else if (word > HdrWidth'(MAX_WORDS)) begin
                        state_d = StError;
                    end else begin
                        state_d    = StData;
                        n_d        = CntW'(word);
                        word_cnt_d = '0;
                    end
                end
            end
            StData: begin
                // The write registers sit apart from the packer, so DATA never stalls.
                if (word_valid) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = BASE_ADDR + (ADDR_WIDTH'(word_cnt_q) << 2);
                    mem_wd_d   = word;
                    word_cnt_d = word_cnt_q + CntW'(1);
                    if (word_cnt_d == n_q) begin
                        state_d = StDone;
                    end
                end
            end
            StDone, StError: begin
                if (restart && !mem_we_q) begin
                    state_d    = StHdr;
                    word_cnt_d = '0;
                    n_d        = '0;
                    packer_clr = 1'b1;
                end
            end
            default: begin
                state_d = StHdr;
            end
        endcase
    end

    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_wd   = mem_wd_q;
    assign done     = (state_q == StDone);
    assign error    = (state_q == StError);
    // The final write pulse occupies the first DONE cycle; release only after it.
    assign cpu_hold = !((state_q == StDone) && !mem_we_q);

endmodule
